// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: captures a WIDTH-bit word on load and sends it LSB first.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             w_accept;
  logic             w_last;
`ifdef PISO_PARITY_EN
  logic             r_par;
`endif

  // Handshake: load is accepted on a rising edge with load=1 and busy=0;
  // a load seen while busy=1 is dropped silently and never queued.
  assign w_accept = (r_state == S_IDLE) && load;
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (load) w_next = S_SHIFT;
`ifdef PISO_PARITY_EN
      S_SHIFT:  if (w_last) w_next = S_PARITY;
      S_PARITY: w_next = S_IDLE;
`else
      S_SHIFT:  if (w_last) w_next = S_IDLE;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    case (r_state)
      S_SHIFT: begin
        sout       = r_shift[0];
        sout_valid = 1'b1;
        busy       = 1'b1;
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        sout       = r_par;
        sout_valid = 1'b1;
        busy       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
`ifdef PISO_PARITY_EN
      r_done <= (r_state == S_PARITY);
`else
      r_done <= w_last;
`endif
      if (w_accept) begin
        r_shift <= D;
        r_cnt   <= '0;
`ifdef PISO_PARITY_EN
        r_par   <= ^D;
`endif
      end else if (r_state == S_SHIFT) begin
        // Counter reaches WIDTH on the final shift, which CW bits always hold.
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_piso_serializer.sv
// Table-driven bench for piso_serializer (WIDTH=4): cycle-by-cycle vectors plus a
// hand-written asynchronous-reset sequence.
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] D;
  logic       sout;
  logic       sout_valid;
  logic       busy;
  logic       done;
  logic [1:0] o_dbg_state;

  int n_pass;
  int n_total;

  typedef struct {
    logic       ld;
    logic [3:0] d;
    logic [3:0] exp;  // {sout, sout_valid, busy, done} after the edge
  } vec_t;

  vec_t vecs[$];

  piso_serializer #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .D           (D),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (o_dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [3:0] exp);
    logic [3:0] got;
    got = {sout, sout_valid, busy, done};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: sout/valid/busy/done got %b expected %b at %0t", nm, got, exp, $time);
  endtask

  task automatic add(input logic ld, input logic [3:0] d, input logic [3:0] exp);
    vec_t v;
    v.ld  = ld;
    v.d   = d;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  localparam logic [3:0] IDLE = 4'b0000;
  localparam logic [3:0] BIT0 = 4'b0110;
  localparam logic [3:0] BIT1 = 4'b1110;
  localparam logic [3:0] DONE = 4'b0001;

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    load    = 1'b0;
    D       = 4'b0000;

    // Idle after reset
    add(1'b0, 4'b0000, IDLE);
    add(1'b0, 4'b0000, IDLE);
    add(1'b0, 4'b0000, IDLE);
    // 1010, single load pulse
    add(1'b1, 4'b1010, BIT0);
    add(1'b0, 4'b0000, BIT1);
    add(1'b0, 4'b0000, BIT0);
    add(1'b0, 4'b0000, BIT1);
`ifdef PISO_PARITY_EN
    add(1'b0, 4'b0000, BIT0);
`endif
    add(1'b0, 4'b0000, DONE);
    add(1'b0, 4'b0000, IDLE);
    // 1011, with an ignored load of 1111 during bit 1
    add(1'b1, 4'b1011, BIT1);
    add(1'b0, 4'b0000, BIT1);
    add(1'b1, 4'b1111, BIT0);
    add(1'b0, 4'b0000, BIT1);
`ifdef PISO_PARITY_EN
    add(1'b0, 4'b0000, BIT1);
`endif
    add(1'b0, 4'b0000, DONE);
    add(1'b0, 4'b0000, IDLE);
    // load held high with 0101: back-to-back frames, one done cycle between
    for (int f = 0; f < 2; f++) begin
      add(1'b1, 4'b0101, BIT1);
      add(1'b1, 4'b0101, BIT0);
      add(1'b1, 4'b0101, BIT1);
      add(1'b1, 4'b0101, BIT0);
`ifdef PISO_PARITY_EN
      add(1'b1, 4'b0101, BIT0);
`endif
      add(1'b1, 4'b0101, DONE);
    end
    add(1'b0, 4'b0000, IDLE);

    // Reset is asynchronous: outputs must already be zero before any edge.
    #1;
    check("reset_async_t1", IDLE);
    #9;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_release", IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      load = vecs[i].ld;
      D    = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Abort 1100 during bit 2 with an asynchronous reset
    load = 1'b1;
    D    = 4'b1100;
    @(posedge clk);
    #1;
    check("abort_bit0", BIT0);
    load = 1'b0;
    @(posedge clk);
    #1;
    check("abort_bit1", BIT0);
    @(posedge clk);
    #1;
    check("abort_bit2", BIT1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_async_clear", IDLE);
    @(posedge clk);
    #1;
    check("abort_no_done", IDLE);
    // Load presented with reset still high must lose to reset
    load = 1'b1;
    D    = 4'b1111;
    @(posedge clk);
    #1;
    check("reset_over_load", IDLE);
    reset = 1'b0;
    D     = 4'b0011;
    @(posedge clk);
    #1;
    check("post_reset_bit0", BIT1);
    load = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_bit1", BIT1);
    @(posedge clk);
    #1;
    check("post_reset_bit2", BIT0);
    @(posedge clk);
    #1;
    check("post_reset_bit3", BIT0);
`ifdef PISO_PARITY_EN
    @(posedge clk);
    #1;
    check("post_reset_parity", BIT0);
`endif
    @(posedge clk);
    #1;
    check("post_reset_done", DONE);
    @(posedge clk);
    #1;
    check("post_reset_idle", IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..16).
REQ-002 Port clk SHALL be an input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-004 Port load SHALL be an input, 1 bit: request to capture D and start a serial frame.
REQ-005 Port D SHALL be an input, WIDTH bits: parallel word to transmit.
REQ-006 Port sout SHALL be an output, 1 bit: serial data, LSB first.
REQ-007 Port sout_valid SHALL be an output, 1 bit: high while sout carries a frame bit.
REQ-008 Port busy SHALL be an output, 1 bit: high while a frame is in progress.
REQ-009 Port done SHALL be an output, 1 bit: one-cycle pulse after the last frame bit.

Function
REQ-010 The block SHALL implement a state machine with states IDLE, SHIFT and PARITY; PARITY exists only when PISO_PARITY_EN is defined.
REQ-011 The load handshake SHALL be accepted on a rising edge where load=1 and busy=0.
- On acceptance: D is captured into the shift register; bit counter = 0; state -> SHIFT.
REQ-012 A load while busy=1 SHALL be ignored: no capture, the frame in flight is unaffected, and no error is flagged.
REQ-013 In IDLE the block SHALL drive sout=0, sout_valid=0 and busy=0.
REQ-014 In SHIFT the block SHALL output the captured word, one bit per cycle:
- sout = shift register bit 0; sout_valid=1; busy=1.
- Each rising edge shifts the register right by one (zero fill) and increments the counter.
REQ-015 Latency: the first bit (captured D[0]) SHALL appear in the cycle immediately after the accepting edge; bit k appears k cycles later.
REQ-016 At the edge where counter = WIDTH-1, the state SHALL move to PARITY if parity is enabled, else to IDLE with done set.
REQ-017 done SHALL be registered and high for exactly one cycle, coincident with the first cycle in which busy=0.
REQ-018 A load asserted in the done cycle SHALL be accepted, giving back-to-back frames with exactly one idle cycle between them.
REQ-019 Frame length SHALL be WIDTH cycles of sout_valid=1, or WIDTH+1 cycles with parity enabled.
REQ-020 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within a frame.
REQ-021 busy, sout and sout_valid SHALL be functions of registered state only, with no combinational path from load or D.

Reset
REQ-022 Asserting reset SHALL immediately, without waiting for a clock edge, force: state=IDLE, shift register=0, counter=0, parity register=0, done=0, sout=0, sout_valid=0, busy=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame without a done pulse; a load on the first edge after reset deassertion SHALL be accepted.
REQ-024 Reset SHALL take priority over load on the same edge.

Configuration
REQ-025 The parity feature SHALL be controlled by the macro PISO_PARITY_EN.
REQ-026 With PISO_PARITY_EN defined:
- Even parity of D (XOR of all bits) is captured at load acceptance.
- The parity bit is sent in one PARITY cycle after the data bits, with sout_valid=1 and busy=1.
- done follows in the next cycle.
REQ-027 With PISO_PARITY_EN undefined: no parity register, no PARITY state; done follows the last data bit.

Verification
REQ-028 Bench SHALL cover: reset=1 for 10 time units, then reset=0 with load=0 -> sout=0, sout_valid=0, busy=0, done=0 throughout.
REQ-029 Bench SHALL cover: D=4'b1010, load pulsed 1 cycle -> sout = 0,1,0,1 on the following 4 cycles with sout_valid=1; then done=1 for 1 cycle with busy=0 (with parity: extra bit 0 before done).
REQ-030 Bench SHALL cover: D=4'b1011 loaded, then load=1 with D=4'b1111 on the 2nd bit cycle -> ignored; sout = 1,1,0,1 unaltered (with parity: extra bit 1).
REQ-031 Bench SHALL cover: load held high continuously with D=4'b0101 -> sout = 1,0,1,0, then a done cycle, then the next frame starts; repeats with a 1-cycle gap.
REQ-032 Bench SHALL cover: reset=1 asserted asynchronously during bit 2 of D=4'b1100 -> all outputs 0 before the next clock edge, no done pulse; load of 4'b0011 right after release -> sout = 1,1,0,0.
